// File: rtl/demux_1x8_sync_if.sv
// Bus bundle for the registered 1-to-8 demux: shared source in/sel, eight routed outputs.
interface demux_1x8_sync_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] in;
    logic [2:0]       sel;
    logic [WIDTH-1:0] y0, y1, y2, y3, y4, y5, y6, y7;

    modport master (
        output in, sel,
        input  y0, y1, y2, y3, y4, y5, y6, y7
    );

    modport slave (
        input  in, sel,
        output y0, y1, y2, y3, y4, y5, y6, y7
    );
endinterface

// File: rtl/demux_1x8_sync.sv
// Registered 1-to-8 demultiplexer: in is routed to the output selected by sel,
// all other outputs are cleared at the same edge.
module demux_1x8_lane #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hit,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // Unselected lanes load zero every cycle rather than holding their value.
    always_ff @(posedge clk) begin
        if (rst)      q <= '0;
        else if (hit) q <= d;
        else          q <= '0;
    end
endmodule

module demux_1x8_sync #(
    parameter int WIDTH = 1
) (
    input  logic              clk,
    input  logic              rst,
    demux_1x8_sync_if.slave   bus
);
    localparam int NUM_LANES = 8;

    logic [NUM_LANES-1:0]            hit;
    logic [NUM_LANES-1:0][WIDTH-1:0] y_q;

    // Full decode; an unknown sel matches no lane, so every output clears.
    always_comb begin
        hit = '0;
        case (bus.sel)
            3'd0:    hit = 8'b0000_0001;
            3'd1:    hit = 8'b0000_0010;
            3'd2:    hit = 8'b0000_0100;
            3'd3:    hit = 8'b0000_1000;
            3'd4:    hit = 8'b0001_0000;
            3'd5:    hit = 8'b0010_0000;
            3'd6:    hit = 8'b0100_0000;
            3'd7:    hit = 8'b1000_0000;
            default: hit = '0;
        endcase
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        demux_1x8_lane #(.WIDTH(WIDTH)) u_lane (
            .clk (clk),
            .rst (rst),
            .hit (hit[i]),
            .d   (bus.in),
            .q   (y_q[i])
        );
    end

    assign bus.y0 = y_q[0];
    assign bus.y1 = y_q[1];
    assign bus.y2 = y_q[2];
    assign bus.y3 = y_q[3];
    assign bus.y4 = y_q[4];
    assign bus.y5 = y_q[5];
    assign bus.y6 = y_q[6];
    assign bus.y7 = y_q[7];
endmodule

// File: tb/tb_demux_1x8_sync.sv
// Scoreboard bench for demux_1x8_sync at WIDTH=4: driver queues hand-computed
// output vectors {y7..y0}, a monitor pops and compares one per clock edge.
module tb_demux_1x8_sync;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    demux_1x8_sync_if #(.WIDTH(W)) bus ();

    demux_1x8_sync #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8*W-1:0] exp;
        string          name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    logic [8*W-1:0] act;
    assign act = {bus.y7, bus.y6, bus.y5, bus.y4, bus.y3, bus.y2, bus.y1, bus.y0};

    // Inputs change at the falling edge; the expectation is queued right after
    // the rising edge that samples them.
    task automatic step(input logic r, input logic [W-1:0] d, input logic [2:0] s,
                        input logic [8*W-1:0] exp, input string name);
        exp_t e;
        @(negedge clk);
        rst     = r;
        bus.in  = d;
        bus.sel = s;
        @(posedge clk);
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    // Monitor: one registered result per edge, sampled 1 time unit after it.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in  = '0;
        bus.sel = '0;

        // Reset held with data present: nothing routes
        step(1'b1, 4'h1, 3'd5, 32'h0000_0000, "reset_0");
        step(1'b1, 4'h1, 3'd5, 32'h0000_0000, "reset_1");
        step(1'b0, 4'h1, 3'd5, 32'h0010_0000, "release_y5");

        // Zero sweep
        for (int k = 0; k < 8; k++)
            step(1'b0, 4'h0, 3'(k), 32'h0000_0000, $sformatf("zero_sel%0d", k));

        // One-hot sweep
        for (int k = 0; k < 8; k++)
            step(1'b0, 4'h1, 3'(k), 32'h1 << (4*k), $sformatf("onehot_sel%0d", k));

        // Back-to-back switching
        step(1'b0, 4'h1, 3'd3, 32'h0000_1000, "b2b_y3");
        step(1'b0, 4'h1, 3'd6, 32'h0100_0000, "b2b_y6");

        // Mid-stream reset pulse
        step(1'b0, 4'h1, 3'd2, 32'h0000_0100, "mid_y2");
        step(1'b1, 4'h1, 3'd2, 32'h0000_0000, "mid_rst");
        step(1'b0, 4'h1, 3'd2, 32'h0000_0100, "mid_resume");

        // Wide data, bit ordering preserved
        step(1'b0, 4'hA, 3'd7, 32'hA000_0000, "wide_y7_A");
        step(1'b0, 4'h0, 3'd7, 32'h0000_0000, "wide_y7_0");
        step(1'b0, 4'h5, 3'd0, 32'h0000_0005, "wide_y0_5");
        step(1'b0, 4'hF, 3'd4, 32'h000F_0000, "wide_y4_F");
        step(1'b0, 4'h6, 3'd1, 32'h0000_0060, "wide_y1_6");
        step(1'b1, 4'hF, 3'd4, 32'h0000_0000, "wide_rst_prio");

        repeat (2) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/demux_1x8_sync.md
# demux_1x8_sync

Registered 1-to-8 demultiplexer. Routes the `in` data input to exactly one of eight outputs, `y0`..`y7`, selected by the 3-bit `sel`. All other outputs are driven to zero. Outputs are registered on the single system clock and cleared by a synchronous active-high reset. It sits in the data-routing layer, feeding per-channel consumers from a shared source.

## Interface
Parameters:
- `WIDTH`, default 1, bit width of `in` and of each output `y0`..`y7`.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset; sampled only on the rising edge of `clk`.
- `in`  input  WIDTH  data to be routed.
- `sel`  input  3  output select, binary-encoded: 0 selects `y0`, 7 selects `y7`.
- `y0`..`y7`  output  WIDTH each  registered demux outputs.

## Operation
- The rising edge of `clk` is the only event that changes outputs. Outputs do not respond combinationally to `in`, `sel` or `rst`.
- Reset: if `rst`=1 at the edge, all of `y0`..`y7` become 0, regardless of `in` and `sel`.
- Normal operation, `rst`=0 at the edge:
  - `y[sel]` takes `in`.
  - Every other output becomes 0.
  - Unselected outputs are actively cleared every cycle, never held.
- Exactly one output can be non-zero at any time. It can be non-zero only when `in` was non-zero at the last edge.
- `in`=0 leaves all outputs 0 for every `sel` value.
- Decode is full: all 8 `sel` codes are defined.
  - `sel` containing X/Z in simulation drives all outputs to 0. This is the default branch.
- All bits of the selected output follow the corresponding bits of `in`; there is no bit reordering.
- Arithmetic: none. Pure routing. No widening or truncation between `in` and outputs.

## Timing
- Latency: 1 clock. `in`/`sel` sampled at edge N appear on the outputs immediately after edge N.
- Throughput: one new `in`/`sel` pair accepted every cycle. No handshake and no stall.
- Reset value of every output: 0 (all WIDTH bits).
  - Before the first edge, outputs are 0 if initialised; otherwise undefined until the first edge.
- Reset has priority over data when both occur at the same edge.
- Reset asserted mid-stream: outputs are 0 after the first edge with `rst`=1.
  - They stay 0 while `rst` is held.
  - Routing resumes at the first edge with `rst`=0, using the `in`/`sel` sampled at that edge.
- `sel` changing every cycle: each edge produces an independent one-hot result. There is no glitch-carrying from the previous selection; the previous output clears at the same edge the new one loads.
- Input changes between edges have no effect on the outputs.

## Test plan
- Reset: `rst`=1, `in`=1, `sel`=3'b101 for 2 edges -> all of `y0`..`y7` = 0. Release `rst` -> after the next edge `y5`=1 and the others 0.
- Zero sweep: `in`=0, `sel` stepped 0..7, one per cycle -> every output is 0 after every edge.
- One-hot sweep: `in`=1, `sel` stepped 0..7, one per cycle -> after edge k only `yk`=1, checked against the expected vector with a 1-cycle delay.
- Back-to-back switching: `in`=1, `sel`=3 then 6 on consecutive edges -> `y3`=1 for exactly one cycle, then `y6`=1 with `y3`=0 at the same edge.
- Mid-stream reset: `in`=1, `sel`=2, `rst` pulsed high for 1 cycle -> `y2` falls to 0 for that cycle and returns to 1 on the following edge.
- Wide data (WIDTH=4): `in`=4'hA, `sel`=7 -> `y7`=4'hA and the other seven outputs = 4'h0. Then `in`=4'h0 -> all outputs are 0.
